// File: rtl/mmd_divider.sv
// rtl/mmd_divider.sv - multi-modulus divider counter fed by the sigma-delta div_ctrl word (optional stats: DIV_STATS_EN)
module mmd_divider #(
    parameter int w        = 6,
    parameter int MIN_DIV  = 2,
    parameter int RST_DIV  = 30,
    parameter int AVG_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [w-1:0]          div_ctrl,
    input  logic                  mod_vld,
    output logic                  mod_rdy,
    input  logic                  clr_flags,
    output logic                  tick,
    output logic                  div_out,
    output logic [w-1:0]          mod_cur,
    output logic                  underrun,
    output logic                  clamped,
    output logic [w+AVG_LOG2-1:0] avg_sum,
    output logic                  avg_vld
);

    localparam logic [w-1:0] MIN_W = w'(MIN_DIV);
    localparam logic [w-1:0] RST_W = w'(RST_DIV);
    localparam logic [w-1:0] ONE_W = w'(1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t         state;
    logic [w-1:0]   cnt;
    logic [w-1:0]   next_mod;
    logic           ctrl_low;

    assign ctrl_low = (div_ctrl < MIN_W);
    assign mod_rdy  = (state == LOAD) || ((state == RUN) && (cnt == '0) && en);
    assign tick     = (state == RUN) && (cnt == '0);
    assign div_out  = (state == RUN) && (cnt >= (mod_cur >> 1));

    // Modulus chosen at a load: clamped request, or the previous modulus when no word is offered
    always_comb begin
        next_mod = mod_cur;
        if (mod_vld) begin
            next_mod = ctrl_low ? MIN_W : div_ctrl;
        end
    end

    // Period FSM, down-counter, modulus register and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mod_cur  <= RST_W;
            underrun <= 1'b0;
            clamped  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE_W;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (mod_rdy) begin
                mod_cur <= next_mod;
                cnt     <= next_mod - ONE_W;
            end

            // clear first so a same-cycle set event wins
            if (clr_flags) begin
                underrun <= 1'b0;
                clamped  <= 1'b0;
            end
            if (mod_rdy && !mod_vld) begin
                underrun <= 1'b1;
            end
            if (mod_rdy && mod_vld && ctrl_low) begin
                clamped <= 1'b1;
            end
        end
    end

`ifdef DIV_STATS_EN
    logic [w+AVG_LOG2-1:0] acc;
    logic [AVG_LOG2-1:0]   pcnt;
    logic [w+AVG_LOG2-1:0] sum_now;

    assign sum_now = acc + {{AVG_LOG2{1'b0}}, mod_cur};

    // Sum moduli over 2^AVG_LOG2 periods; publish and restart when the window closes
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            pcnt    <= '0;
            avg_sum <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (tick) begin
                if (pcnt == '1) begin
                    avg_sum <= sum_now;
                    avg_vld <= 1'b1;
                    acc     <= '0;
                    pcnt    <= '0;
                end else begin
                    acc  <= sum_now;
                    pcnt <= pcnt + AVG_LOG2'(1);
                end
                // a tick with en low is the entry to IDLE: window restarts
                if (!en) begin
                    acc  <= '0;
                    pcnt <= '0;
                end
            end
        end
    end
`else
    assign avg_sum = '0;
    assign avg_vld = 1'b0;
`endif

endmodule

// File: doc/mmd_divider.md
Name: mmd_divider

Overview:
- Multi-modulus divider counter. It is the consumer of the sigma-delta modulator's 6-bit div_ctrl word in the fractional-N synthesizer.
- Each output period lasts exactly M clk cycles, where M is the modulus accepted at the start of that period.
- At every period boundary it requests the next modulus through a valid/ready handshake, and it emits a tick that clocks-enables the modulator.
- Sits between the modulator and the PLL feedback/phase-detector path.

Parameters:
- w, 6, modulus width (matches div_ctrl width)
- MIN_DIV, 2, smallest legal modulus; smaller requests are clamped up to this value
- RST_DIV, 30, modulus used when no valid word is available at the first load
- AVG_LOG2, 4, log2 of the averaging window in periods (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- div_ctrl  in  w  next modulus (unsigned)
- mod_vld  in  1  div_ctrl is valid
- mod_rdy  out  1  divider is sampling div_ctrl this cycle
- clr_flags  in  1  clears the sticky flags
- tick  out  1  one-cycle pulse on the last cycle of each period
- div_out  out  1  divided clock, high for ceil(M/2) cycles at the start of each period
- mod_cur  out  w  modulus of the period in progress
- underrun  out  1  sticky: mod_rdy occurred while mod_vld=0
- clamped  out  1  sticky: an accepted div_ctrl was below MIN_DIV
- avg_sum  out  w+AVG_LOG2  sum of moduli over the averaging window
- avg_vld  out  1  avg_sum updated this cycle

Behaviour:
- All state updates on posedge clk. rst has priority over every other input.
- Reset values: state=IDLE, cnt=0, mod_cur=RST_DIV, mod_rdy=0, tick=0, div_out=0, underrun=0, clamped=0, avg_sum=0, avg_vld=0.
- States:
  - IDLE: en=1 -> LOAD.
  - LOAD: unconditional -> RUN.
  - RUN, cnt>0: cnt decrements.
  - RUN, cnt==0, en=1: reload, stay in RUN.
  - RUN, cnt==0, en=0: -> IDLE.
- mod_rdy is combinational: asserted when state==LOAD, or when state==RUN && cnt==0 && en==1.
- Load rule, on every mod_rdy cycle:
  - M = mod_vld ? max(div_ctrl, MIN_DIV) : mod_cur.
  - mod_cur <= M; cnt <= M-1.
  - If mod_vld=0, set underrun (the previous modulus is reused).
  - If mod_vld=1 and div_ctrl<MIN_DIV, set clamped.
- tick = (state==RUN && cnt==0). Consecutive periods are gapless: period length equals M exactly.
- div_out = (state==RUN && cnt >= mod_cur>>1), so it is high for ceil(M/2) cycles per period.
- Latency:
  - en rising in IDLE gives mod_rdy on the next cycle (LOAD).
  - The first cycle of the first period follows the LOAD cycle.
  - The first tick comes M cycles after LOAD.
- en deasserted mid-period: the current period completes with its tick. No mod_rdy is issued at that tick. Next state is IDLE.
- In IDLE, mod_cur holds its value.
- clr_flags clears underrun and clamped. If a set event occurs in the same cycle as clr_flags, the set wins.
- Modulus arithmetic is unsigned w-bit. A value of 0 is clamped, never wrapped.
- Synchronous reset in any state returns to IDLE within one cycle. A partial period is discarded.

Optional Feature:
- Macro: DIV_STATS_EN.
- Defined:
  - Adds a (w+AVG_LOG2)-bit accumulator and an AVG_LOG2-bit period counter. Both are cleared on rst and on entry to IDLE.
  - On each tick, mod_cur is added to the accumulator.
  - After 2^AVG_LOG2 ticks, avg_sum <= the full sum including the current mod_cur, and avg_vld pulses in the following cycle.
  - The accumulator then restarts at 0.
- Not defined: avg_sum and avg_vld are tied to 0 and no accumulator logic exists. The port list is unchanged.

Test Plan:
- Reset, en=1, mod_vld=1, div_ctrl=30 constant -> mod_rdy at cycle 1; ticks every 30 cycles; div_out high 15 cycles / low 15 cycles; flags stay 0.
- Alternate div_ctrl 29/31, accepted on each mod_rdy -> period lengths alternate 29,31; mod_cur follows the accepted value; div_out high 15/16 cycles respectively.
- div_ctrl=1, then div_ctrl=0 -> both periods are 2 cycles; clamped=1; clr_flags pulse -> clamped=0.
- mod_vld=0 on one mod_rdy after a period with M=25 -> next period is 25 cycles; underrun=1 until clr_flags.
- en dropped 5 cycles into a 30-cycle period -> the tick still occurs 25 cycles later; no mod_rdy; IDLE; outputs 0. rst asserted mid-period -> IDLE on the next cycle with all reset values.
- With DIV_STATS_EN, AVG_LOG2=4, 16 periods of alternating 29/31 -> avg_sum=480, avg_vld a single-cycle pulse. Without the macro -> avg_sum=0 and avg_vld=0 throughout.
